in_arb_regs_mq: RTL and testbench

Parametrised register block for the multi-queue input arbiter. It sits on the UDP register ring next to the arbiter datapath and does four things:
- keeps one saturating, clear-on-read packet counter per input queue;
- exposes the arbiter state and the downstream ready flag;
- snapshots the first CAPTURE_WORDS words (data and ctrl) of the most recent packet, with a software freeze control;
- answers ring requests that hit its tag one cycle later and forwards all other requests unchanged.

---
 rtl/in_arb_regs_mq.sv | 228 ++++++++++++++++++++++
 tb/tb_in_arb_regs_mq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/in_arb_regs_mq.sv
// in_arb_regs_mq
// Register block for the multi-queue input arbiter, sitting on the UDP
// register ring.
//   - One saturating, clear-on-access packet counter per input queue,
//     bumped by eop/eop_queue.
//   - STATUS register with one-cycle-latched arbiter state and out_rdy.
//   - Snapshot of the first CAPTURE_WORDS words (data + ctrl) of the most
//     recent packet seen on out_wr/out_data/out_ctrl, gated by CONTROL.FREEZE.
//   - Ring slave: requests that hit BLOCK_TAG are answered one cycle later;
//     everything else is passed through with a one-cycle delay.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reg_*_in / reg_*_out       register ring in / registered ring out
//   state, out_rdy             arbiter queue pointer, downstream ready
//   out_wr, out_ctrl, out_data arbiter output word stream
//   eop, eop_queue             packet-finished pulse and its source queue

`timescale 1ns/1ps

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module in_arb_regs_mq #(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH/8,
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int NUM_QUEUES        = 8,
  parameter int CAPTURE_WORDS     = 2,
  parameter int BLOCK_ADDR_WIDTH  = 8,
  parameter int BLOCK_TAG         = 0
) (
  input  logic                             clk,
  input  logic                             reset,

  input  logic                             reg_req_in,
  input  logic                             reg_ack_in,
  input  logic                             reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_in,

  output logic                             reg_req_out,
  output logic                             reg_ack_out,
  output logic                             reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]   reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]  reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]     reg_src_out,

  input  logic [$clog2(NUM_QUEUES)-1:0]    state,
  input  logic                             out_wr,
  input  logic [CTRL_WIDTH-1:0]            out_ctrl,
  input  logic [DATA_WIDTH-1:0]            out_data,
  input  logic                             out_rdy,
  input  logic                             eop,
  input  logic [$clog2(NUM_QUEUES)-1:0]    eop_queue
);

  localparam int ADDR_W   = `UDP_REG_ADDR_WIDTH;
  localparam int TAG_W    = ADDR_W - BLOCK_ADDR_WIDTH;
  localparam int L        = $clog2(NUM_QUEUES);
  localparam int C        = DATA_WIDTH / 32;
  localparam int CAP_BASE = 2 + NUM_QUEUES;
  localparam int NUM_REGS = CAP_BASE + CAPTURE_WORDS * (C + 1);
  localparam int WIDX_W   = $clog2(CAPTURE_WORDS + 1);

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  logic [BLOCK_ADDR_WIDTH-1:0] offset;
  logic                        tag_hit;

  assign offset  = reg_addr_in[BLOCK_ADDR_WIDTH-1:0];
  assign tag_hit = reg_req_in &&
                   (reg_addr_in[ADDR_W-1:BLOCK_ADDR_WIDTH] == TAG_W'(BLOCK_TAG));

  // Every readable word, flattened in register-map order.
  logic [NUM_REGS-1:0][31:0] rd_file;
  logic [31:0]               rd_val;

  // ---------------------------------------------------------------------
  // CONTROL / STATUS
  // ---------------------------------------------------------------------
  logic           freeze_reg;
  logic [L-1:0]   state_latched_reg;
  logic           out_rdy_latched_reg;

  assign rd_file[0] = 32'(freeze_reg);
  assign rd_file[1] = 32'({state_latched_reg, out_rdy_latched_reg});

  always_ff @(posedge clk) begin
    if (reset) begin
      freeze_reg          <= 1'b0;
      state_latched_reg   <= '0;
      out_rdy_latched_reg <= 1'b0;
    end else begin
      state_latched_reg   <= state;
      out_rdy_latched_reg <= out_rdy;
      if (tag_hit && !reg_rd_wr_L_in && offset == '0)
        freeze_reg <= reg_data_in[0];
    end
  end

  // ---------------------------------------------------------------------
  // Per-queue packet counters
  // ---------------------------------------------------------------------
  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_QUEUES; gi++) begin : g_cnt
      logic [31:0] cnt_reg;
      logic [31:0] cnt_next;
      logic        clr;
      logic        inc;

      always_comb begin
        clr      = tag_hit && (offset == BLOCK_ADDR_WIDTH'(2 + gi));
        inc      = eop && (eop_queue == L'(gi));
        cnt_next = cnt_reg;
        // A clearing access wins over the old value, but an eop in the same
        // cycle must not be lost: it becomes the first count after the clear.
        if (clr)
          cnt_next = inc ? 32'd1 : 32'd0;
        else if (inc && cnt_reg != 32'hFFFF_FFFF)
          cnt_next = cnt_reg + 32'd1;
      end

      always_ff @(posedge clk) begin
        if (reset) cnt_reg <= '0;
        else       cnt_reg <= cnt_next;
      end

      assign rd_file[2 + gi] = cnt_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Packet capture tracking
  // ---------------------------------------------------------------------
  logic              in_pkt_reg;
  logic [WIDX_W-1:0] word_idx_reg;
  logic              first_word;
  logic              mid_word;

  assign first_word = out_wr && !in_pkt_reg && (out_ctrl == '0);
  assign mid_word   = out_wr && in_pkt_reg;

  // Tracking runs regardless of FREEZE so that unfreezing in the middle of a
  // packet does not misalign the next capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_pkt_reg   <= 1'b0;
      word_idx_reg <= '0;
    end else if (first_word) begin
      in_pkt_reg   <= 1'b1;
      word_idx_reg <= WIDX_W'(1);
    end else if (mid_word) begin
      if (word_idx_reg < WIDX_W'(CAPTURE_WORDS))
        word_idx_reg <= word_idx_reg + WIDX_W'(1);
      if (out_ctrl != '0)
        in_pkt_reg <= 1'b0;
    end
  end

  generate
    for (gi = 0; gi < CAPTURE_WORDS; gi++) begin : g_cap
      logic [DATA_WIDTH-1:0] data_reg;
      logic [CTRL_WIDTH-1:0] ctrl_reg;
      logic                  we;

      assign we = !freeze_reg &&
                  (first_word ? (gi == 0)
                              : (mid_word && word_idx_reg == WIDX_W'(gi)));

      always_ff @(posedge clk) begin
        if (reset) begin
          data_reg <= '0;
          ctrl_reg <= '0;
        end else if (we) begin
          data_reg <= out_data;
          ctrl_reg <= out_ctrl;
        end
      end

      for (gj = 0; gj < C; gj++) begin : g_chunk
        assign rd_file[CAP_BASE + gi*(C+1) + gj] = data_reg[gj*32 +: 32];
      end
      assign rd_file[CAP_BASE + gi*(C+1) + C] = 32'(ctrl_reg);
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Read mux and ring outputs
  // ---------------------------------------------------------------------
  always_comb begin
    rd_val = 32'hDEAD_BEEF;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (offset == BLOCK_ADDR_WIDTH'(i))
        rd_val = rd_file[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_src_out     <= reg_src_in;
      if (tag_hit) begin
        reg_ack_out  <= 1'b1;
        reg_data_out <= reg_rd_wr_L_in ? rd_val : reg_data_in;
      end else begin
        reg_ack_out  <= reg_ack_in;
        reg_data_out <= reg_data_in;
      end
    end
  end

endmodule

// File: tb/tb_in_arb_regs_mq.sv
`timescale 1ns/1ps

`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_in_arb_regs_mq;

  localparam int AW       = `UDP_REG_ADDR_WIDTH;
  localparam int NQ       = 8;
  localparam int CAP_BASE = 10;
  localparam int NUM_REGS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0] reg_addr_in;
  logic [31:0]   reg_data_in;
  logic [1:0]    reg_src_in;
  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [31:0]   reg_data_out;
  logic [1:0]    reg_src_out;
  logic [2:0]    state;
  logic          out_wr;
  logic [7:0]    out_ctrl;
  logic [63:0]   out_data;
  logic          out_rdy;
  logic          eop;
  logic [2:0]    eop_queue;

  int total = 0;
  int bad   = 0;

  // Expected {ack, data} of each request, in issue order.
  logic [32:0] sb_q[$];

  always #5 clk = ~clk;

  in_arb_regs_mq dut (
    .clk(clk), .reset(reset),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in),
    .reg_rd_wr_L_in(reg_rd_wr_L_in), .reg_addr_in(reg_addr_in),
    .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out),
    .reg_rd_wr_L_out(reg_rd_wr_L_out), .reg_addr_out(reg_addr_out),
    .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .state(state), .out_wr(out_wr), .out_ctrl(out_ctrl), .out_data(out_data),
    .out_rdy(out_rdy), .eop(eop), .eop_queue(eop_queue)
  );

  // Scoreboard: every request reappears on reg_req_out exactly one cycle
  // later, and its ack/data must match what was pushed at issue time.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset && reg_req_out) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp: got ack=%b data=%h addr=%h want no response",
                 reg_ack_out, reg_data_out, reg_addr_out);
      end else begin
        e = sb_q.pop_front();
        if ({reg_ack_out, reg_data_out} !== e) begin
          bad++;
          $display("FAIL resp addr=%h: got ack=%b data=%h want ack=%b data=%h",
                   reg_addr_out, reg_ack_out, reg_data_out, e[32], e[31:0]);
        end else begin
          $display("resp addr=%h ack=%b data=%h ok", reg_addr_out, reg_ack_out, reg_data_out);
        end
      end
    end
  end

  task automatic send_req(input logic rd, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input logic ack_in,
                          input logic [32:0] exp);
    reg_req_in     = 1'b1;
    reg_rd_wr_L_in = rd;
    reg_addr_in    = addr;
    reg_data_in    = wdata;
    reg_ack_in     = ack_in;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    reg_req_in     = 1'b0;
    reg_rd_wr_L_in = 1'b0;
    reg_ack_in     = 1'b0;
    reg_data_in    = '0;
  endtask

  task automatic rd(input int off, input logic [31:0] exp);
    send_req(1'b1, AW'(off), 32'h0, 1'b0, {1'b1, exp});
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    send_req(1'b0, AW'(off), d, 1'b0, {1'b1, d});
  endtask

  task automatic pulse_eop(input int q);
    eop = 1'b1; eop_queue = 3'(q);
    @(posedge clk); #1;
    eop = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] d, input logic [7:0] c);
    out_wr = 1'b1; out_data = d; out_ctrl = c;
    @(posedge clk); #1;
    out_wr = 1'b0; out_data = '0; out_ctrl = '0;
  endtask

  task automatic send_pkt(input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2);
    send_word(d0, 8'h00);
    send_word(d1, 8'h00);
    send_word(d2, 8'h80);
    @(posedge clk); #1;
  endtask

  task automatic read_captures(input logic [63:0] d0, input logic [63:0] d1);
    rd(CAP_BASE + 0, d0[31:0]);
    rd(CAP_BASE + 1, d0[63:32]);
    rd(CAP_BASE + 2, 32'h0);
    rd(CAP_BASE + 3, d1[31:0]);
    rd(CAP_BASE + 4, d1[63:32]);
    rd(CAP_BASE + 5, 32'h0);
  endtask

  task automatic test_reset();
    // Request presented while reset is held must be dropped.
    reg_req_in = 1'b1; reg_rd_wr_L_in = 1'b1; reg_addr_in = AW'(2); reg_ack_in = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b ack=%b addr=%h data=%h want all zero",
               reg_req_out, reg_ack_out, reg_addr_out, reg_data_out);
    end
    reset = 1'b0; reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    @(posedge clk); #1;
    total++;
    if (reg_ack_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_drop: got ack=%b want ack=0", reg_ack_out);
    end
    $display("reset checked");
    rd(0, 32'h0);
    rd(1, 32'h0);
    rd(2, 32'h0);
    rd(NUM_REGS, 32'hDEAD_BEEF);
  endtask

  task automatic test_counters();
    for (int i = 0; i < 5; i++) pulse_eop(3);
    pulse_eop(4); pulse_eop(4);
    rd(5, 32'd5);
    rd(5, 32'd0);
    for (int i = 0; i < 3; i++) pulse_eop(3);
    // eop on the same queue during the clearing read
    eop = 1'b1; eop_queue = 3'd3;
    rd(5, 32'd3);
    eop = 1'b0;
    rd(5, 32'd1);
    // eop the cycle after a clearing read lands in the cleared counter
    pulse_eop(3);
    rd(5, 32'd1);
    pulse_eop(3);
    rd(5, 32'd1);
    rd(6, 32'd2);
    rd(6, 32'd0);
  endtask

  task automatic test_status();
    state = 3'd5; out_rdy = 1'b1;
    @(posedge clk); #1;
    // Inputs change with the read; STATUS must still show the previous sample.
    state = 3'd2; out_rdy = 1'b0;
    rd(1, 32'h0000_000B);
    rd(1, 32'h0000_0004);
    state = 3'd0;
  endtask

  task automatic test_capture();
    send_pkt(64'h0011_2233_4455_6677, 64'hAABB_CCDD_EEFF_0102, 64'h5555_6666_7777_8888);
    read_captures(64'h0011_2233_4455_6677, 64'hAABB_CCDD_EEFF_0102);
  endtask

  task automatic test_freeze();
    wr(0, 32'h1);
    // Packet starts the cycle right after the CONTROL write.
    send_pkt(64'h1111_1111_2222_2222, 64'h3333_3333_4444_4444, 64'h0);
    rd(0, 32'h1);
    read_captures(64'h0011_2233_4455_6677, 64'hAABB_CCDD_EEFF_0102);
    wr(0, 32'h0);
    send_pkt(64'hCAFE_0000_BEEF_0001, 64'h0BAD_F00D_1234_5678, 64'h0);
    rd(0, 32'h0);
    read_captures(64'hCAFE_0000_BEEF_0001, 64'h0BAD_F00D_1234_5678);
  endtask

  task automatic test_tag_miss();
    pulse_eop(0); pulse_eop(0);
    send_req(1'b1, AW'((1 << 8) | 2), 32'h1234, 1'b1, {1'b1, 32'h0000_1234});
    send_req(1'b0, AW'((1 << 8) | 0), 32'h1, 1'b0, {1'b0, 32'h0000_0001});
    rd(2, 32'd2);
    rd(0, 32'h0);
  endtask

  task automatic test_saturation();
    force dut.g_cnt[7].cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.g_cnt[7].cnt_reg;
    pulse_eop(7);
    pulse_eop(7);
    pulse_eop(7);
    rd(9, 32'hFFFF_FFFF);
    rd(9, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = 2'd1;
    state = '0; out_wr = 1'b0; out_ctrl = '0; out_data = '0;
    out_rdy = 1'b0; eop = 1'b0; eop_queue = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_counters();
    test_status();
    test_capture();
    test_freeze();
    test_tag_miss();
    test_saturation();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL missing_resp: got %0d outstanding want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
